// File: rtl/inc_counter_pkg.sv
// rtl/inc_counter_pkg.sv - shared types and limits for the run counter
package inc_counter_pkg;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/IncC.sv
// rtl/IncC.sv - parallel-prefix incrementer, o_z = i_a + i_ci, o_co = carry-out
module IncC #(
  parameter int width = 8,
  parameter int speed = 1
) (
  input  logic [width-1:0] i_a,
  input  logic             i_ci,
  output logic [width-1:0] o_z,
  output logic             o_co
);

  localparam int N = width + 1;
  localparam int L = $clog2(N);

  logic [N-1:0] w_g;
  logic [N-1:0] w_p;

  assign w_g = {i_a, i_ci};

  // w_p[i] is the AND of w_g[0..i]: the carry into bit i of i_a
  always_comb begin
    w_p = w_g;
    case (speed)
      0: begin
        for (int i = 1; i < N; i++) w_p[i] = w_p[i] & w_p[i-1];
      end
      1: begin
        for (int l = 1; l <= L; l++)
          for (int i = 0; i < N; i++)
            if (((i + 1) % (1 << l)) == 0)
              w_p[i] = w_p[i] & w_p[i - (1 << (l - 1))];
        for (int l = L - 1; l >= 1; l--)
          for (int i = 0; i < N; i++)
            if ((((i + 1) % (1 << l)) == (1 << (l - 1))) && (i >= (1 << l)))
              w_p[i] = w_p[i] & w_p[i - (1 << (l - 1))];
      end
      default: begin
        for (int l = 0; l < L; l++)
          for (int i = 0; i < N; i++)
            if (((i >> l) & 1) == 1)
              w_p[i] = w_p[i] & w_p[((i >> l) << l) - 1];
      end
    endcase
  end

  assign o_z  = i_a ^ w_p[width-1:0];
  assign o_co = w_p[width];

endmodule

// File: rtl/inc_counter.sv
// rtl/inc_counter.sv - start/limit run counter with wrap flag and ack handshake
module inc_counter
  import inc_counter_pkg::*;
#(
  parameter int width = 8,
  parameter int speed = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [width-1:0] init_i,
  input  logic [width-1:0] limit_i,
  input  logic             en_i,
  input  logic             ack_i,
  input  logic             abort_i,
  output logic [width-1:0] cnt_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             wrap_o
);

  state_e           r_state;
  state_e           w_next;
  logic [width-1:0] r_cnt;
  logic [width-1:0] r_lim;
  logic             r_wrap;
  logic [width-1:0] w_sum;
  logic             w_co;
  logic             w_eq;
  logic             w_load;
  logic             w_step;

  IncC #(
    .width(width),
    .speed(speed)
  ) u_incc (
    .i_a (r_cnt),
    .i_ci(1'b1),
    .o_z (w_sum),
    .o_co(w_co)
  );

  assign w_eq   = (r_cnt == r_lim);
  assign w_load = (r_state == ST_IDLE) && start_i && !abort_i;
  assign w_step = (r_state == ST_RUN) && en_i && !w_eq && !abort_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= ST_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (abort_i) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (start_i)      w_next = ST_RUN;
        ST_RUN:  if (en_i && w_eq) w_next = ST_DONE;
        ST_DONE: if (ack_i)        w_next = ST_IDLE;
        default:                   w_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    busy_o = (r_state == ST_RUN);
    done_o = (r_state == ST_DONE);
    cnt_o  = r_cnt;
    wrap_o = r_wrap;
  end

  // wrap is sticky across DONE/IDLE so the consumer can read it after the run
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt  <= '0;
      r_lim  <= '0;
      r_wrap <= 1'b0;
    end else if (w_load) begin
      r_cnt  <= init_i;
      r_lim  <= limit_i;
      r_wrap <= 1'b0;
    end else if (w_step) begin
      r_cnt <= w_sum;
      if (w_co) r_wrap <= 1'b1;
    end
  end

endmodule

// File: tb/tb_inc_counter.sv
// tb/tb_inc_counter.sv - self-checking bench for inc_counter, all three speed variants
module tb_inc_counter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] init = 8'h00;
  logic [7:0] limit = 8'h00;
  logic       en = 1'b0;
  logic       ack = 1'b0;
  logic       abort = 1'b0;

  logic [7:0] cnt_o [3];
  logic       busy_o [3];
  logic       done_o [3];
  logic       wrap_o [3];

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    inc_counter #(.width(8), .speed(g)) u_dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .start_i(start),
      .init_i (init),
      .limit_i(limit),
      .en_i   (en),
      .ack_i  (ack),
      .abort_i(abort),
      .cnt_o  (cnt_o[g]),
      .busy_o (busy_o[g]),
      .done_o (done_o[g]),
      .wrap_o (wrap_o[g])
    );
  end

  // reference: phase 0 idle, 1 counting, 2 finished
  int m_phase = 0;
  int m_cnt = 0;
  int m_lim = 0;
  bit m_wrap = 1'b0;

  task automatic model_reset();
    m_phase = 0; m_cnt = 0; m_lim = 0; m_wrap = 1'b0;
  endtask

  task automatic model_clock();
    if (abort) begin
      m_phase = 0;
    end else if (m_phase == 0) begin
      if (start) begin
        m_cnt = int'(init); m_lim = int'(limit); m_wrap = 1'b0; m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (en) begin
        if (m_cnt == m_lim) m_phase = 2;
        else begin
          if (m_cnt + 1 == 256) m_wrap = 1'b1;
          m_cnt = (m_cnt + 1) % 256;
        end
      end
    end else if (ack) begin
      m_phase = 0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic [7:0] e_cnt, input logic e_busy,
                           input logic e_done, input logic e_wrap);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("%s s%0d cnt", tag, k), 64'(cnt_o[k]), 64'(e_cnt));
      check($sformatf("%s s%0d busy", tag, k), 64'(busy_o[k]), 64'(e_busy));
      check($sformatf("%s s%0d done", tag, k), 64'(done_o[k]), 64'(e_done));
      check($sformatf("%s s%0d wrap", tag, k), 64'(wrap_o[k]), 64'(e_wrap));
    end
  endtask

  typedef struct {
    logic       start;
    logic [7:0] init;
    logic [7:0] limit;
    logic       en;
    logic       ack;
    logic       abort;
    logic [7:0] e_cnt;
    logic       e_busy;
    logic       e_done;
    logic       e_wrap;
  } vec_t;

  vec_t tbl [$];

  function automatic vec_t v(logic s, logic [7:0] i, logic [7:0] l, logic e, logic a,
                             logic ab, logic [7:0] c, logic b, logic d, logic w);
    vec_t r;
    r.start = s; r.init = i; r.limit = l; r.en = e; r.ack = a; r.abort = ab;
    r.e_cnt = c; r.e_busy = b; r.e_done = d; r.e_wrap = w;
    return r;
  endfunction

  initial begin
    // count 10..13 then handshake; start with ack in DONE is ignored
    tbl.push_back(v(1, 8'h10, 8'h13, 0, 0, 0, 8'h10, 1, 0, 0));
    tbl.push_back(v(0, 8'h00, 8'h00, 1, 0, 0, 8'h11, 1, 0, 0));
    tbl.push_back(v(0, 8'h00, 8'h00, 1, 0, 0, 8'h12, 1, 0, 0));
    tbl.push_back(v(0, 8'h00, 8'h00, 1, 0, 0, 8'h13, 1, 0, 0));
    tbl.push_back(v(0, 8'h00, 8'h00, 1, 0, 0, 8'h13, 0, 1, 0));
    tbl.push_back(v(0, 8'h00, 8'h00, 0, 0, 0, 8'h13, 0, 1, 0));
    tbl.push_back(v(1, 8'h77, 8'h78, 0, 1, 0, 8'h13, 0, 0, 0));
    tbl.push_back(v(0, 8'h00, 8'h00, 1, 0, 0, 8'h13, 0, 0, 0));
    // wrap FE,FF,00,01
    tbl.push_back(v(1, 8'hFE, 8'h01, 0, 0, 0, 8'hFE, 1, 0, 0));
    tbl.push_back(v(0, 8'h00, 8'h00, 1, 0, 0, 8'hFF, 1, 0, 0));
    tbl.push_back(v(0, 8'h00, 8'h00, 1, 0, 0, 8'h00, 1, 0, 1));
    tbl.push_back(v(0, 8'h00, 8'h00, 1, 0, 0, 8'h01, 1, 0, 1));
    tbl.push_back(v(0, 8'h00, 8'h00, 1, 0, 0, 8'h01, 0, 1, 1));
    tbl.push_back(v(0, 8'h00, 8'h00, 0, 1, 0, 8'h01, 0, 0, 1));
    // init == limit
    tbl.push_back(v(1, 8'h55, 8'h55, 0, 0, 0, 8'h55, 1, 0, 0));
    tbl.push_back(v(0, 8'h00, 8'h00, 1, 0, 0, 8'h55, 0, 1, 0));
    tbl.push_back(v(0, 8'h00, 8'h00, 0, 1, 0, 8'h55, 0, 0, 0));
    // en toggling, start in RUN ignored, abort holds cnt
    tbl.push_back(v(1, 8'h20, 8'h30, 0, 0, 0, 8'h20, 1, 0, 0));
    tbl.push_back(v(0, 8'h00, 8'h00, 1, 0, 0, 8'h21, 1, 0, 0));
    tbl.push_back(v(0, 8'h00, 8'h00, 0, 0, 0, 8'h21, 1, 0, 0));
    tbl.push_back(v(0, 8'h00, 8'h00, 1, 0, 0, 8'h22, 1, 0, 0));
    tbl.push_back(v(0, 8'h00, 8'h00, 0, 0, 0, 8'h22, 1, 0, 0));
    tbl.push_back(v(1, 8'h99, 8'h9A, 1, 0, 0, 8'h23, 1, 0, 0));
    tbl.push_back(v(0, 8'h00, 8'h00, 1, 0, 1, 8'h23, 0, 0, 0));
    tbl.push_back(v(0, 8'h00, 8'h00, 1, 0, 0, 8'h23, 0, 0, 0));
    // abort in DONE beats ack/start; abort in IDLE beats start
    tbl.push_back(v(1, 8'h40, 8'h40, 0, 0, 0, 8'h40, 1, 0, 0));
    tbl.push_back(v(0, 8'h00, 8'h00, 1, 0, 0, 8'h40, 0, 1, 0));
    tbl.push_back(v(1, 8'h66, 8'h67, 1, 1, 1, 8'h40, 0, 0, 0));
    tbl.push_back(v(1, 8'h66, 8'h67, 0, 0, 1, 8'h40, 0, 0, 0));
    tbl.push_back(v(0, 8'h00, 8'h00, 0, 0, 0, 8'h40, 0, 0, 0));
    // abort holds a set wrap flag
    tbl.push_back(v(1, 8'hFF, 8'h05, 0, 0, 0, 8'hFF, 1, 0, 0));
    tbl.push_back(v(0, 8'h00, 8'h00, 1, 0, 0, 8'h00, 1, 0, 1));
    tbl.push_back(v(0, 8'h00, 8'h00, 1, 0, 1, 8'h00, 0, 0, 1));

    #1;
    check_all("reset", 8'h00, 0, 0, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    step();
    check_all("idle_after_reset", 8'h00, 0, 0, 0);

    for (int t = 0; t < tbl.size(); t++) begin
      start = tbl[t].start; init = tbl[t].init; limit = tbl[t].limit;
      en = tbl[t].en; ack = tbl[t].ack; abort = tbl[t].abort;
      step();
      check_all($sformatf("vec%0d", t), tbl[t].e_cnt, tbl[t].e_busy, tbl[t].e_done, tbl[t].e_wrap);
    end
    start = 0; en = 0; ack = 0; abort = 0;

    // asynchronous reset mid-run at cnt 0x33
    start = 1; init = 8'h30; limit = 8'h40;
    step();
    start = 0; en = 1;
    step(); step(); step();
    check_all("pre_reset", 8'h33, 1, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check_all("async_reset", 8'h00, 0, 0, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    step();
    check_all("after_reset_idle", 8'h00, 0, 0, 0);
    step();
    check_all("after_reset_stays", 8'h00, 0, 0, 0);
    en = 0;

    // random run against the reference
    for (int c = 0; c < 10000 && n_fail < 50; c++) begin
      start = ($urandom_range(0, 3) != 0);
      init  = 8'($urandom);
      limit = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'(init + 8'($urandom_range(0, 12)));
      en    = ($urandom_range(0, 3) != 0);
      ack   = ($urandom_range(0, 2) == 0);
      abort = ($urandom_range(0, 49) == 0);
      step();
      check_all($sformatf("rand%0d", c), 8'(m_cnt), m_phase == 1, m_phase == 2, m_wrap);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
